// File: rtl/pingpang_reader.sv
`default_nettype none
// ============================================================================
// Module   : pingpang_reader
// Brief    : Alternates INCR read bursts between two AXI read masters, merges
//            the returned beats in address order into a credit-guarded FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module pingpang_reader #(
    parameter int C_M_AXI_BURST_LEN  = 16,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int ADDR_WIDTH         = 32,
    parameter int FIFO_DEPTH         = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [ADDR_WIDTH-1:0]         Base_ADDR,
    input  logic [ADDR_WIDTH-1:0]         End_ADDR,
    output logic                          INIT_AXI_TXN_1,
    output logic                          INIT_AXI_TXN_2,
    input  logic                          INIT_AXI_TXN_DONE_1,
    input  logic                          INIT_AXI_TXN_DONE_2,
    output logic [ADDR_WIDTH-1:0]         BIAS_ADDR_1,
    output logic [ADDR_WIDTH-1:0]         BIAS_ADDR_2,
    input  logic                          Data_valid_1,
    input  logic                          Data_valid_2,
    output logic                          Data_ready_1,
    output logic                          Data_ready_2,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] Data_1,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] Data_2,
    output logic                          out_valid,
    output logic [C_M_AXI_DATA_WIDTH-1:0] out_data,
    input  logic                          out_ready,
    output logic                          Read_done,
    output logic [1:0]                    current_state,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int c_FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W   = c_FIFO_AW + 1;
    localparam int c_BEAT_W  = (C_M_AXI_BURST_LEN > 1) ? $clog2(C_M_AXI_BURST_LEN) : 1;
    localparam logic [ADDR_WIDTH-1:0] c_BURST_BYTES =
        ADDR_WIDTH'(C_M_AXI_BURST_LEN * C_M_AXI_DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] c_ADDRESS_CHANGE =
        ADDR_WIDTH'(2 * C_M_AXI_BURST_LEN * C_M_AXI_DATA_WIDTH / 8);
    localparam logic [c_CNT_W-1:0]  c_CREDIT_INIT  = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0]  c_CREDIT_BURST = c_CNT_W'(C_M_AXI_BURST_LEN);
    localparam logic [c_BEAT_W-1:0] c_BEAT_LAST    = c_BEAT_W'(C_M_AXI_BURST_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                    r_state;
    logic                      r_start_q;
    logic                      r_init_1, r_init_2;
    logic                      r_busy_1, r_busy_2;
    logic [ADDR_WIDTH-1:0]     r_bias_1, r_bias_2;
    logic [c_CNT_W-1:0]        r_credit;
    logic                      r_launch_ptr;   // 0 = M1, 1 = M2
    logic                      r_rd_ptr;       // master owning the oldest burst
    logic [c_BEAT_W-1:0]       r_beat_cnt;
    logic                      r_read_done;

    logic [C_M_AXI_DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_FIFO_AW-1:0]      r_wr_idx, r_rd_idx;
    logic [c_CNT_W-1:0]        r_count;

    logic                      w_start_flag;
    logic                      w_sel_busy;
    logic [ADDR_WIDTH-1:0]     w_sel_bias;
    logic [ADDR_WIDTH-1:0]     w_span;
    logic                      w_range_ok, w_credit_ok, w_launch;
    logic                      w_done_1, w_done_2;
    logic                      w_push, w_pop;
    logic [C_M_AXI_DATA_WIDTH-1:0] w_push_data;

    assign w_start_flag = start & ~r_start_q;
    assign w_sel_busy   = r_launch_ptr ? r_busy_2 : r_busy_1;
    assign w_sel_bias   = r_launch_ptr ? r_bias_2 : r_bias_1;
    assign w_span       = End_ADDR - Base_ADDR;
    assign w_range_ok   = (w_sel_bias + c_BURST_BYTES) <= w_span;
    assign w_credit_ok  = r_credit >= c_CREDIT_BURST;
    assign w_launch     = (r_state == S_RUN) && start && !w_sel_busy && w_credit_ok && w_range_ok;
    assign w_done_1     = INIT_AXI_TXN_DONE_1 & r_busy_1;
    assign w_done_2     = INIT_AXI_TXN_DONE_2 & r_busy_2;

    // Only the master holding the oldest outstanding burst may hand over beats.
    assign Data_ready_1 = !r_rd_ptr && r_busy_1 && (r_state != S_IDLE);
    assign Data_ready_2 =  r_rd_ptr && r_busy_2 && (r_state != S_IDLE);
    assign w_push       = (Data_ready_1 & Data_valid_1) | (Data_ready_2 & Data_valid_2);
    assign w_push_data  = r_rd_ptr ? Data_2 : Data_1;
    assign w_pop        = out_valid & out_ready;

    assign INIT_AXI_TXN_1 = r_init_1;
    assign INIT_AXI_TXN_2 = r_init_2;
    assign BIAS_ADDR_1    = r_bias_1;
    assign BIAS_ADDR_2    = r_bias_2;
    assign Read_done      = r_read_done;
    assign current_state  = r_state;
    assign out_valid      = (r_count != '0);
    assign out_data       = r_mem[r_rd_idx];
    assign fifo_count     = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_start_q    <= 1'b0;
            r_init_1     <= 1'b0;
            r_init_2     <= 1'b0;
            r_busy_1     <= 1'b0;
            r_busy_2     <= 1'b0;
            r_bias_1     <= '0;
            r_bias_2     <= c_BURST_BYTES;
            r_credit     <= c_CREDIT_INIT;
            r_launch_ptr <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_beat_cnt   <= '0;
            r_read_done  <= 1'b0;
        end else begin
            r_start_q <= start;
            r_init_1  <= w_launch && !r_launch_ptr;
            r_init_2  <= w_launch &&  r_launch_ptr;

            if (w_done_1) begin
                r_busy_1 <= 1'b0;
                r_bias_1 <= r_bias_1 + c_ADDRESS_CHANGE;
            end else if (w_launch && !r_launch_ptr) begin
                r_busy_1 <= 1'b1;
            end

            if (w_done_2) begin
                r_busy_2 <= 1'b0;
                r_bias_2 <= r_bias_2 + c_ADDRESS_CHANGE;
            end else if (w_launch && r_launch_ptr) begin
                r_busy_2 <= 1'b1;
            end

            if (w_launch) begin
                r_launch_ptr <= ~r_launch_ptr;
            end

            // A burst's FIFO space is reserved at launch and returned word by word.
            r_credit <= r_credit - (w_launch ? c_CREDIT_BURST : '0) + (w_pop ? c_CNT_W'(1) : '0);

            if (w_push) begin
                if (r_beat_cnt == c_BEAT_LAST) begin
                    r_beat_cnt <= '0;
                    r_rd_ptr   <= ~r_rd_ptr;
                end else begin
                    r_beat_cnt <= r_beat_cnt + 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start_flag) begin
                        r_state      <= S_RUN;
                        r_bias_1     <= '0;
                        r_bias_2     <= c_BURST_BYTES;
                        r_credit     <= c_CREDIT_INIT;
                        r_launch_ptr <= 1'b0;
                        r_rd_ptr     <= 1'b0;
                        r_beat_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    if (!start || (!w_sel_busy && w_credit_ok && !w_range_ok)) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!r_busy_1 && !r_busy_2 && (r_count == '0)) begin
                        r_state     <= S_DONE;
                        r_read_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (!start) begin
                        r_state     <= S_IDLE;
                        r_read_done <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_idx <= r_wr_idx + 1'b1;
            end
            if (w_pop) begin
                r_rd_idx <= r_rd_idx + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_idx] <= w_push_data;
        end
    end

endmodule
`default_nettype wire
